// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared types and defaults for the memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_IF   = 1'b1
    } owner_t;

    localparam int c_DEF_TIMEOUT    = 255;
    localparam int c_DEF_STARVE_MAX = 4;

endpackage

`default_nettype wire

// File: rtl/arb_watchdog.sv
// ============================================================================
// Module      : arb_watchdog
// Description : 8-bit wait counter; expired when the count reaches TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_watchdog
    import core_pkg::*;
#(
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] c_LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (tick && (cnt_q != c_LIMIT)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired = (cnt_q == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Fetch/data arbiter onto one memory port, one transaction in
//               flight. Optional fetch anti-starvation: ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = c_DEF_TIMEOUT,
    parameter int STARVE_MAX = c_DEF_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic                  if_err,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic                  d_err,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_be,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata
);

    arb_state_t          state_q;
    logic                if_valid_q, if_err_q, d_valid_q, d_err_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;

    logic   w_resp_busy;
    logic   w_arb_open;
    logic   w_starved;
    logic   w_grant;
    logic   w_expired;
    owner_t w_owner;

    // Holding off arbitration during a response pulse keeps gnt/valid/err exclusive.
    assign w_resp_busy = if_valid_q | if_err_q | d_valid_q | d_err_q;
    assign w_arb_open  = !rst && (state_q == IDLE) && !w_resp_busy;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 2);

    logic [STARVE_W-1:0] starve_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else if (if_gnt) begin
            starve_q <= '0;
        end else if (d_gnt && if_req && (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign w_starved = (starve_q == STARVE_W'(STARVE_MAX));
`else
    // Never true for a legal STARVE_MAX: data keeps strict priority.
    assign w_starved = (STARVE_MAX < 0);
`endif

    assign w_owner = (if_req && (w_starved || !d_req)) ? OWN_IF : OWN_DATA;

    assign m_req   = w_arb_open && (if_req || d_req);
    assign m_we    = (w_owner == OWN_IF) ? 1'b0    : d_we;
    assign m_addr  = (w_owner == OWN_IF) ? if_addr : d_addr;
    assign m_wdata = (w_owner == OWN_IF) ? '0      : d_wdata;
    assign m_be    = (w_owner == OWN_IF) ? '1      : d_be;

    assign w_grant = m_req && m_ready;
    assign if_gnt  = w_grant && (w_owner == OWN_IF);
    assign d_gnt   = w_grant && (w_owner == OWN_DATA);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (w_grant),
        .tick    ((state_q != IDLE) && !m_rvalid),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_grant) begin
                        state_q <= (w_owner == OWN_IF) ? WAIT_IF : WAIT_D;
                    end
                end
                WAIT_IF: begin
                    if (m_rvalid) begin
                        if_rdata_q <= m_rdata;
                        if_valid_q <= 1'b1;
                        state_q    <= IDLE;
                    end else if (w_expired) begin
                        if_err_q   <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                WAIT_D: begin
                    if (m_rvalid) begin
                        d_rdata_q <= m_rdata;
                        d_valid_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (w_expired) begin
                        d_err_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_valid = if_valid_q;
    assign if_err   = if_err_q;
    assign if_rdata = if_rdata_q;
    assign d_valid  = d_valid_q;
    assign d_err    = d_err_q;
    assign d_rdata  = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter (scoreboard queue).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_valid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_gnt, d_valid, d_err;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ready = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    // Inputs change at negedge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        next_cycle();
        if_req = 1'b1; d_req = 1'b1; m_ready = 1'b1;
        #1;
        n_cmp++;
        if ({m_req, if_gnt, d_gnt} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_mreq: got m_req/if_gnt/d_gnt=%b%b%b want 000", m_req, if_gnt, d_gnt);
        end
        n_cmp++;
        if ({if_valid, if_err, d_valid, d_err} !== 4'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outs: got v/e=%b%b%b%b if_rdata=%h d_rdata=%h want all 0",
                     if_valid, if_err, d_valid, d_err, if_rdata, d_rdata);
        end
        next_cycle();
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_fetch();
        exp_t e;
        next_cycle();
        if_req = 1'b1; if_addr = 32'h0000_0010; m_ready = 1'b1;
        #1;
        n_cmp++;
        if ({m_req, m_we, m_be, if_gnt, d_gnt} !== 8'b1_0_1111_1_0 || m_addr !== 32'h10) begin
            n_bad++;
            $display("FAIL fetch_cmd: got req=%b we=%b be=%h gnt=%b/%b addr=%h want 1 0 f 1/0 00000010",
                     m_req, m_we, m_be, if_gnt, d_gnt, m_addr);
        end
        next_cycle();
        if_req = 1'b0;
        #1;
        n_cmp++;
        if (m_req !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_wait_mreq: got %b want 0", m_req);
        end
        next_cycle();
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'h0050_0093;
        sb.push_back('{is_if: 1'b1, data: 32'h0050_0093});
        #1;
        n_cmp++;
        if (if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_early_valid: got %b want 0", if_valid);
        end
        next_cycle();
        m_rvalid = 1'b0; m_rdata = '0;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (if_valid !== e.is_if || d_valid !== 1'b0 || if_rdata !== e.data) begin
            n_bad++;
            $display("FAIL fetch_resp: got if_valid=%b d_valid=%b rdata=%h want 1 0 %h",
                     if_valid, d_valid, if_rdata, e.data);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (if_valid !== 1'b0 || if_rdata !== 32'h0050_0093) begin
            n_bad++;
            $display("FAIL fetch_hold: got valid=%b rdata=%h want 0 00500093", if_valid, if_rdata);
        end
    endtask

    task automatic test_conflict();
        exp_t e;
        next_cycle();
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
        #1;
        n_cmp++;
        if ({d_gnt, if_gnt, m_we, m_be} !== 7'b1_0_1_1111 || m_addr !== 32'h100 || m_wdata !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL conflict_cmd: got d/if_gnt=%b%b we=%b be=%h addr=%h wdata=%h want 10 1 f 100 deadbeef",
                     d_gnt, if_gnt, m_we, m_be, m_addr, m_wdata);
        end
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        #1;
        n_cmp++;
        if (m_req !== 1'b0 || if_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_holdoff: got m_req=%b if_gnt=%b want 0 0", m_req, if_gnt);
        end
        next_cycle();
        m_rvalid = 1'b1; m_rdata = '0;
        sb.push_back('{is_if: 1'b0, data: 32'h0});
        next_cycle();
        m_rvalid = 1'b0;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ((e.is_if ? if_valid : d_valid) !== 1'b1 || if_gnt !== 1'b0 || m_req !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_dvalid: got d_valid=%b if_gnt=%b m_req=%b want 1 0 0", d_valid, if_gnt, m_req);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (if_gnt !== 1'b1 || m_addr !== 32'h20 || d_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_ifgnt: got if_gnt=%b addr=%h d_valid=%b want 1 20 0", if_gnt, m_addr, d_valid);
        end
        next_cycle();
        if_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        sb.push_back('{is_if: 1'b1, data: 32'h1234_5678});
        next_cycle();
        m_rvalid = 1'b0;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (if_valid !== 1'b1 || if_rdata !== e.data) begin
            n_bad++;
            $display("FAIL conflict_ifresp: got valid=%b rdata=%h want 1 %h", if_valid, if_rdata, e.data);
        end
    endtask

    task automatic test_timeout();
        bit bad;
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF; m_ready = 1'b1;
        #1;
        n_cmp++;
        if (d_gnt !== 1'b1 || m_we !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_gnt: got d_gnt=%b m_we=%b want 1 0", d_gnt, m_we);
        end
        bad = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            next_cycle();
            d_req = 1'b0; if_req = (k <= 200);
            #1;
            if (d_err || d_valid || if_gnt || m_req) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL timeout_wait: got activity during 256 wait cycles want none");
        end
        next_cycle();
        #1;
        n_cmp++;
        if (d_err !== 1'b1 || d_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_err: got d_err=%b d_valid=%b want 1 0", d_err, d_valid);
        end
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'hBAD0_0BAD;
        #1;
        n_cmp++;
        if (d_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse: got d_err=%b want 0", d_err);
        end
        next_cycle();
        m_rvalid = 1'b0;
        #1;
        n_cmp++;
        if (d_valid !== 1'b0 || d_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_late: got d_valid=%b d_err=%b want 0 0", d_valid, d_err);
        end
    endtask

    task automatic test_rvalid_at_timeout();
        exp_t e;
        next_cycle();
        if_req = 1'b1; if_addr = 32'h30; m_ready = 1'b1;
        next_cycle();
        if_req = 1'b0;
        for (int k = 2; k <= 255; k++) next_cycle();
        next_cycle();
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001;
        sb.push_back('{is_if: 1'b1, data: 32'hCAFE_0001});
        next_cycle();
        m_rvalid = 1'b0;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (if_valid !== 1'b1 || if_err !== 1'b0 || if_rdata !== e.data) begin
            n_bad++;
            $display("FAIL rvalid_wins: got valid=%b err=%b rdata=%h want 1 0 %h", if_valid, if_err, if_rdata, e.data);
        end
    endtask

    task automatic test_mready_low();
        exp_t e;
        bit   bad;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; m_ready = 1'b0;
            #1;
            if (m_req !== 1'b1 || d_gnt !== 1'b0 || if_gnt !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL mready_low: got no-req or gnt while m_ready=0 want m_req=1 gnt=0");
        end
        next_cycle();
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h44;
        #1;
        n_cmp++;
        if (m_req !== 1'b1 || m_addr !== 32'h44 || m_we !== 1'b0 || if_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL rearb_drop: got req=%b addr=%h we=%b gnt=%b want 1 44 0 0", m_req, m_addr, m_we, if_gnt);
        end
        next_cycle();
        m_ready = 1'b1;
        #1;
        n_cmp++;
        if (if_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL rearb_gnt: got if_gnt=%b want 1", if_gnt);
        end
        next_cycle();
        if_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55;
        sb.push_back('{is_if: 1'b1, data: 32'h55});
        next_cycle();
        m_rvalid = 1'b0;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (if_valid !== 1'b1 || if_rdata !== e.data) begin
            n_bad++;
            $display("FAIL rearb_resp: got valid=%b rdata=%h want 1 %h", if_valid, if_rdata, e.data);
        end
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; m_ready = 1'b1;
        #1;
        n_cmp++;
        if (d_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL rstwait_gnt: got d_gnt=%b want 1", d_gnt);
        end
        next_cycle();
        d_req = 1'b0; if_req = 1'b1; rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h77;
        #1;
        n_cmp++;
        if (m_req !== 1'b0 || if_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL rstwait_mreq: got m_req=%b if_gnt=%b want 0 0", m_req, if_gnt);
        end
        next_cycle();
        rst = 1'b0; if_req = 1'b0; m_rvalid = 1'b0;
        #1;
        n_cmp++;
        if ({d_valid, d_err, if_valid, if_err, d_gnt, if_gnt, m_req} !== 7'b0 ||
            d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rstwait_outs: got flags=%b%b%b%b%b%b%b d_rdata=%h if_rdata=%h want all 0",
                     d_valid, d_err, if_valid, if_err, d_gnt, if_gnt, m_req, d_rdata, if_rdata);
        end
        next_cycle();
        d_req = 1'b1;
        #1;
        n_cmp++;
        if (d_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL rstwait_idle: got d_gnt=%b want 1", d_gnt);
        end
        next_cycle();
        d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h99;
        sb.push_back('{is_if: 1'b0, data: 32'h99});
        next_cycle();
        m_rvalid = 1'b0;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (d_valid !== 1'b1 || d_rdata !== e.data) begin
            n_bad++;
            $display("FAIL rstwait_resp: got valid=%b rdata=%h want 1 %h", d_valid, d_rdata, e.data);
        end
    endtask

    task automatic test_starvation();
        int d_cnt, f_cnt, d_before;
        bit prev, excl_bad;
        d_cnt = 0; f_cnt = 0; d_before = -1; prev = 1'b0; excl_bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h1; d_be = 4'hF;
            if_req = 1'b1; if_addr = 32'h600; m_ready = 1'b1; m_rvalid = prev;
            #1;
            if (if_gnt === 1'b1 && f_cnt == 0) d_before = d_cnt;
            if (d_gnt === 1'b1) d_cnt++;
            if (if_gnt === 1'b1) f_cnt++;
            if ($countones({if_gnt, d_gnt, if_valid, if_err, d_valid, d_err}) > 1) excl_bad = 1'b1;
            prev = if_gnt | d_gnt;
        end
        next_cycle();
        d_req = 1'b0; if_req = 1'b0; m_rvalid = prev;
        next_cycle();
        m_rvalid = 1'b0;
        next_cycle();
        n_cmp++;
        if (excl_bad) begin
            n_bad++;
            $display("FAIL exclusive: got overlapping gnt/valid/err want at most one per cycle");
        end
`ifdef ARB_STARVE_GUARD_EN
        n_cmp++;
        if (d_before != 4 || f_cnt < 1) begin
            n_bad++;
            $display("FAIL starve_guard: got %0d d_gnt before if_gnt (if_gnt=%0d) want 4", d_before, f_cnt);
        end
`else
        n_cmp++;
        if (f_cnt != 0 || d_cnt < 10) begin
            n_bad++;
            $display("FAIL strict_prio: got if_gnt=%0d d_gnt=%0d want 0 and >=10", f_cnt, d_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_timeout();
        test_rvalid_at_timeout();
        test_mready_low();
        test_reset_in_wait();
        test_starvation();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
